// File: rtl/gb_mem_pkg.sv
// Shared memory-map constants and encodings for the MMU port arbiter and its
// OAM DMA sequencer.
package gb_mem_pkg;

  localparam logic [15:0] ADDR_DMA_REG    = 16'hFF46;
  localparam logic [15:0] ADDR_OAM_BASE   = 16'hFE00;
  localparam int          DMA_LEN_DEFAULT = 160;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RD    = 2'd2,
    ST_WR    = 2'd3
  } dma_state_t;

  // Source of the CPU read data in the cycle after the address
  typedef enum logic [1:0] {
    SEL_MEM     = 2'd0,
    SEL_REG     = 2'd1,
    SEL_BLOCKED = 2'd2
  } rd_sel_t;

endpackage

// File: rtl/oam_dma_seq.sv
// OAM DMA sequencer: state machine, byte counter, source/destination addresses.
// Build option OAM_DMA_ECHO_CLAMP_EN folds source pages 0xE0-0xFF down by 0x20.
module oam_dma_seq
  import gb_mem_pkg::*;
#(
  parameter int DMA_LEN     = DMA_LEN_DEFAULT,
  parameter int START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trigger,
  input  logic [7:0]  page,
  output logic        busy,
  output logic        we,
  output logic [15:0] addr,
  output logic [7:0]  src_page
);

  localparam logic [7:0] CNT_LAST = 8'(DMA_LEN - 1);
  localparam logic [1:0] DLY_LAST = 2'((START_DELAY == 0) ? 0 : START_DELAY - 1);
  localparam dma_state_t ST_START = (START_DELAY == 0) ? ST_RD : ST_DELAY;

  dma_state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic [1:0] dly, dly_nxt;
  logic [7:0] page_nxt;

  function automatic logic [7:0] src_base(input logic [7:0] p);
`ifdef OAM_DMA_ECHO_CLAMP_EN
    return (p >= 8'hE0) ? (p - 8'h20) : p;
`else
    return p;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= 8'h00;
      dly      <= 2'd0;
      src_page <= 8'h00;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      dly      <= dly_nxt;
      src_page <= page_nxt;
    end
  end

  // A trigger wins over every state, so a re-trigger simply restarts the copy
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dly_nxt   = dly;
    page_nxt  = src_page;
    if (trigger) begin
      page_nxt  = page;
      cnt_nxt   = 8'h00;
      dly_nxt   = 2'd0;
      state_nxt = ST_START;
    end else begin
      case (state)
        ST_DELAY: begin
          if (dly == DLY_LAST) state_nxt = ST_RD;
          else                 dly_nxt   = dly + 2'd1;
        end
        ST_RD: state_nxt = ST_WR;
        ST_WR: begin
          if (cnt == CNT_LAST) begin
            state_nxt = ST_IDLE;
          end else begin
            cnt_nxt   = cnt + 8'd1;
            state_nxt = ST_RD;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Offset never carries into the page because DMA_LEN <= 256
  always_comb begin
    busy = (state != ST_IDLE);
    we   = (state == ST_WR);
    case (state)
      ST_RD:   addr = {src_base(src_page), cnt};
      ST_WR:   addr = ADDR_OAM_BASE + {8'h00, cnt};
      default: addr = 16'h0000;
    endcase
  end

endmodule

// File: rtl/oam_dma_arbiter.sv
// Shares the single MMU memory port between the CPU and the OAM DMA engine.
// Optional OAM_DMA_ECHO_CLAMP_EN selects echo-RAM source page folding.
module oam_dma_arbiter
  import gb_mem_pkg::*;
#(
  parameter int DMA_LEN     = DMA_LEN_DEFAULT,
  parameter int START_DELAY = 1
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [15:0] iCpuAddr,
  input  logic        iCpuWe,
  input  logic [7:0]  iCpuData,
  output logic [7:0]  oCpuData,
  output logic [15:0] oMemAddr,
  output logic        oMemWe,
  output logic [7:0]  oMemData,
  input  logic [7:0]  iMemData,
  output logic        oDmaBusy
);

  logic        reg_hit;
  logic        trigger;
  logic        dma_busy;
  logic        dma_we;
  logic [15:0] dma_addr;
  logic [7:0]  src_page;
  rd_sel_t     rd_sel_p1, rd_sel_nxt;

  assign reg_hit = (iCpuAddr == ADDR_DMA_REG);
  assign trigger = reg_hit && iCpuWe;

  oam_dma_seq #(
    .DMA_LEN     (DMA_LEN),
    .START_DELAY (START_DELAY)
  ) u_seq (
    .clk      (iClock),
    .rst_n    (iReset),
    .trigger  (trigger),
    .page     (iCpuData),
    .busy     (dma_busy),
    .we       (dma_we),
    .addr     (dma_addr),
    .src_page (src_page)
  );

  assign oDmaBusy = dma_busy;

  // Port mux; reset also forces the port quiet since IDLE is combinational pass-through
  always_comb begin
    oMemAddr = 16'h0000;
    oMemWe   = 1'b0;
    oMemData = 8'h00;
    if (iReset) begin
      if (dma_busy) begin
        oMemAddr = dma_addr;
        oMemWe   = dma_we;
        oMemData = iMemData;
      end else begin
        oMemAddr = iCpuAddr;
        oMemWe   = iCpuWe && !reg_hit;
        oMemData = iCpuData;
      end
    end
  end

  always_comb begin
    if (reg_hit)       rd_sel_nxt = SEL_REG;
    else if (dma_busy) rd_sel_nxt = SEL_BLOCKED;
    else               rd_sel_nxt = SEL_MEM;
  end

  // Read select aligns with the 1-cycle memory latency
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) rd_sel_p1 <= SEL_BLOCKED;
    else         rd_sel_p1 <= rd_sel_nxt;
  end

  always_comb begin
    case (rd_sel_p1)
      SEL_REG:     oCpuData = src_page;
      SEL_MEM:     oCpuData = iMemData;
      default:     oCpuData = 8'hFF;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Randomized bench for oam_dma_arbiter with a slot-schedule reference model.
module tb_oam_dma_arbiter;

  localparam int LEN      = 160;
  localparam int SD       = 1;
  localparam int BUSY_LEN = SD + 2 * LEN;
`ifdef OAM_DMA_ECHO_CLAMP_EN
  localparam logic [7:0] ECHO_SRC = 8'hC1;
`else
  localparam logic [7:0] ECHO_SRC = 8'hE1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  always #5 clk = ~clk;

  oam_dma_arbiter dut (
    .iClock   (clk),
    .iReset   (rst_n),
    .iCpuAddr (cpu_addr),
    .iCpuWe   (cpu_we),
    .iCpuData (cpu_wdata),
    .oCpuData (cpu_rdata),
    .oMemAddr (mem_addr),
    .oMemWe   (mem_we),
    .oMemData (mem_wdata),
    .iMemData (mem_rdata),
    .oDmaBusy (busy)
  );

  // Bench-owned memory behind the port, and the reference's view of it
  logic [7:0] mem     [0:65535];
  logic [7:0] ref_mem [0:65535];

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         t0    = 0;
  bit         active = 0;
  logic [7:0] ref_page = 8'h00;
  bit         exp_is_reg = 0;
  logic [7:0] exp_rd = 8'hFF;
  logic [7:0] last_rd;
  int         busy_cnt, we_cnt, fall_cnt;
  bit         prev_busy = 0;

  function automatic logic [7:0] eff_page(input logic [7:0] p);
`ifdef OAM_DMA_ECHO_CLAMP_EN
    return (p >= 8'hE0) ? p - 8'h20 : p;
`else
    return p;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  // One CPU bus cycle: drive, check at negedge, advance memory and model at posedge
  task automatic step(input logic [15:0] a, input logic w, input logic [7:0] d);
    int p, i;
    bit b, wr_slot;
    logic [15:0] s_addr, src;
    logic        s_we;
    logic [7:0]  s_data;
    cpu_addr  = a;
    cpu_we    = w;
    cpu_wdata = d;
    @(negedge clk);
    p       = cyc - t0;
    b       = active && (p < BUSY_LEN);
    wr_slot = b && (p >= SD) && (((p - SD) % 2) == 1);
    i       = (p >= SD) ? (p - SD) / 2 : 0;
    src     = {eff_page(ref_page), 8'(i)};
    check("busy", busy, b);
    if (busy) busy_cnt++;
    if (prev_busy && !busy) fall_cnt++;
    prev_busy = busy;
    if (mem_we) we_cnt++;
    last_rd = cpu_rdata;
    check("cpu_rdata", cpu_rdata, exp_is_reg ? ref_page : exp_rd);
    if (!b) begin
      check("pt_addr", mem_addr, a);
      check("pt_we", mem_we, w && (a != 16'hFF46));
      check("pt_data", mem_wdata, d);
    end else if (p < SD) begin
      check("delay_we", mem_we, 1'b0);
    end else if (wr_slot) begin
      check("wr_we", mem_we, 1'b1);
      check("wr_addr", mem_addr, 16'(16'hFE00 + i));
      check("wr_data", mem_wdata, ref_mem[src]);
    end else begin
      check("rd_we", mem_we, 1'b0);
      check("rd_addr", mem_addr, src);
    end
    s_addr = mem_addr;
    s_we   = mem_we;
    s_data = mem_wdata;
    @(posedge clk);
    mem_rdata = mem[s_addr];
    if (s_we) mem[s_addr] = s_data;
    cyc++;
    exp_is_reg = (a == 16'hFF46);
    exp_rd     = b ? 8'hFF : ref_mem[a];
    if (wr_slot) ref_mem[16'(16'hFE00 + i)] = ref_mem[src];
    else if (!b && w && a != 16'hFF46) ref_mem[a] = d;
    if (w && a == 16'hFF46) begin
      ref_page = d;
      active   = 1;
      t0       = cyc;
    end else if (active && (cyc - t0) >= BUSY_LEN) begin
      active = 0;
    end
    #1;
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_rdata", cpu_rdata, 8'hFF);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_data", mem_wdata, 8'h00);
    @(posedge clk);
    cyc++;
    #1;
    rst_n      = 1'b1;
    active     = 0;
    ref_page   = 8'h00;
    exp_is_reg = 0;
    exp_rd     = 8'hFF;
    prev_busy  = 0;
  endtask

  task automatic random_read();
    step(16'($urandom_range(0, 65535)), 1'b0, 8'($urandom));
  endtask

  initial begin
    logic [7:0]  before8000, old_fe50;
    logic [15:0] ra;
    int          r;
    rst_n     = 1'b1;
    cpu_addr  = 16'h0000;
    cpu_we    = 1'b0;
    cpu_wdata = 8'h00;
    mem_rdata = 8'h00;
    for (int a = 0; a < 65536; a++) poke(16'(a), 8'($urandom));
    #3;
    reset_pulse();

    // Pass-through write then read back
    step(16'h8010, 1'b1, 8'hA5);
    step(16'h8010, 1'b0, 8'h00);
    step(16'h0000, 1'b0, 8'h00);
    check("pt_readback", last_rd, 8'hA5);
    check("pt_mem", mem[16'h8010], 8'hA5);

    // Full transfer from C000 with CPU blocked throughout
    for (int i = 0; i < LEN; i++) poke(16'(16'hC000 + i), 8'(i) ^ 8'h3C);
    busy_cnt = 0; we_cnt = 0; fall_cnt = 0;
    step(16'hFF46, 1'b1, 8'hC0);
    before8000 = mem[16'h8000];
    for (int k = 0; k < BUSY_LEN + 3; k++) begin
      if (k == 10) step(16'h8000, 1'b0, 8'h00);
      else if (k == 11) begin
        step(16'h8000, 1'b1, ~before8000);
        check("blk_read", last_rd, 8'hFF);
      end else if (k < 300 && $urandom_range(0, 1) == 1)
        step(16'(16'h9000 + $urandom_range(0, 4095)), 1'b1, 8'($urandom));
      else random_read();
    end
    check("dma_busy_len", busy_cnt, BUSY_LEN);
    check("dma_we_pulses", we_cnt, LEN);
    check("blk_mem", mem[16'h8000], before8000);
    for (int i = 0; i < LEN; i++) check("oam_c0", mem[16'(16'hFE00 + i)], 8'(i) ^ 8'h3C);

    // Re-trigger at the 101st busy cycle
    for (int i = 0; i < LEN; i++) poke(16'(16'hD000 + i), 8'($urandom));
    busy_cnt = 0; fall_cnt = 0;
    step(16'hFF46, 1'b1, 8'hC0);
    for (int k = 0; k < 100; k++) random_read();
    step(16'hFF46, 1'b1, 8'hD0);
    for (int k = 0; k < BUSY_LEN + 3; k++) random_read();
    check("retrig_busy_len", busy_cnt, 101 + BUSY_LEN);
    check("retrig_falls", fall_cnt, 1);
    for (int i = 0; i < LEN; i++)
      check("oam_d0", mem[16'(16'hFE00 + i)], mem[16'(16'hD000 + i)]);

    // Reset while byte 80 is being read
    for (int i = 0; i < LEN; i++) poke(16'(16'hC000 + i), 8'(i) ^ 8'h5A);
    old_fe50 = mem[16'hFE50];
    step(16'hFF46, 1'b1, 8'hC0);
    for (int k = 0; k < SD + 160; k++) random_read();
    reset_pulse();
    for (int i = 0; i < 80; i++) check("oam_kept", mem[16'(16'hFE00 + i)], 8'(i) ^ 8'h5A);
    check("oam_fe50", mem[16'hFE50], old_fe50);
    step(16'hFF46, 1'b0, 8'h00);
    step(16'h0000, 1'b0, 8'h00);
    check("rst_page", last_rd, 8'h00);

    // Echo page source
    for (int i = 0; i < 256; i++) begin
      poke(16'(16'hE100 + i), 8'($urandom));
      poke(16'(16'hC100 + i), 8'($urandom));
    end
    step(16'hFF46, 1'b1, 8'hE1);
    for (int k = 0; k < BUSY_LEN + 3; k++) random_read();
    for (int i = 0; i < LEN; i++)
      check("oam_echo", mem[16'(16'hFE00 + i)], mem[{ECHO_SRC, 8'(i)}]);
    step(16'hFF46, 1'b0, 8'h00);
    step(16'h0000, 1'b0, 8'h00);
    check("echo_page", last_rd, 8'hE1);

    // Random traffic with occasional triggers
    for (int k = 0; k < 800; k++) begin
      r = $urandom_range(0, 99);
      if (r < 2) step(16'hFF46, 1'b1, 8'($urandom));
      else if (r < 40) begin
        ra = 16'($urandom_range(0, 65535));
        if (ra == 16'hFF46) ra = 16'hFF47;
        step(ra, 1'b1, 8'($urandom));
      end else random_read();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
# oam_dma_arbiter

Owns the single memory port of the MMU and shares it between the CPU and the OAM DMA engine. A CPU write to 0xFF46 starts a 160-byte copy from page `XX00–XX9F` to OAM `FE00–FE9F`. While the copy runs, the block blocks CPU access to the port. It sits between the CPU bus and the MMU storage (BIOS/VRAM/OAM array).

## Interface
- `DMA_LEN`, 160: bytes per transfer.
- `START_DELAY`, 1: idle cycles between the trigger write and the first read slot (range 0–3).
- `iClock` in 1: sole clock, rising edge.
- `iReset` in 1: asynchronous, active-low reset.
- `iCpuAddr` in 16: CPU address.
- `iCpuWe` in 1: CPU write strobe, one cycle per write.
- `iCpuData` in 8: CPU write data.
- `oCpuData` out 8: CPU read data, valid the cycle after the address.
- `oMemAddr` out 16: shared port address.
- `oMemWe` out 1: shared port write enable.
- `oMemData` out 8: shared port write data.
- `iMemData` in 8: shared port read data, 1-cycle synchronous latency.
- `oDmaBusy` out 1: high from the cycle after the trigger until the last OAM write completes.

## Operation
- States: IDLE, DELAY, RD, WR.
- IDLE: port passes through.
  - `oMemAddr=iCpuAddr`, `oMemWe=iCpuWe`, `oMemData=iCpuData`.
  - Exception: a write with `iCpuAddr==16'hFF46` is intercepted. It is not forwarded (`oMemWe=0`). It loads `rSrcPage=iCpuData`, clears the byte counter to 0, and moves to DELAY (or RD if `START_DELAY==0`).
- DELAY: counts `START_DELAY` cycles, then RD.
- RD: `oMemAddr={rSrcPage,8'h00}+cnt`, `oMemWe=0`. Next state is WR.
- WR: `oMemAddr=16'hFE00+cnt`, `oMemWe=1`, `oMemData=iMemData`.
  - If `cnt==DMA_LEN-1`, go to IDLE and drop busy.
  - Otherwise increment `cnt` and go to RD.
- `cnt` is 8 bits. Source offset addition has no carry into the page, because `DMA_LEN` ≤ 256.
- CPU during DMA (DELAY/RD/WR):
  - Writes are dropped, except writes to 0xFF46.
  - Reads return 8'hFF.
  - The port stays with DMA in every cycle.
- Re-trigger: a CPU write to 0xFF46 during DMA restarts the transfer.
  - Reload page, `cnt=0`, re-enter DELAY.
  - The current WR slot, if any, still completes that cycle.
  - `oDmaBusy` stays high throughout.
- CPU read of 0xFF46 returns `rSrcPage`. This holds in any state.
- `oCpuData` select is registered alongside the address cycle:
  - 0xFF46 read gives `rSrcPage`.
  - Access blocked by DMA gives 8'hFF.
  - Otherwise `iMemData`.
- Reset (`iReset==0`, asynchronous):
  - State IDLE, `cnt=0`, `rSrcPage=8'h00`, `oDmaBusy=0`.
  - Read select forced to BLOCKED, so `oCpuData=8'hFF`.
  - `oMemWe=0`, `oMemAddr=16'h0000`, `oMemData=8'h00`.
  - Reset mid-transfer aborts it. The OAM bytes already written are kept.

## Timing
- Trigger write at edge N → `oDmaBusy=1` after edge N.
- First RD slot after `START_DELAY` cycles.
- Byte i: RD at cycle N+1+`START_DELAY`+2i, WR one cycle later.
- Busy falls after the final WR edge. Total busy duration is `START_DELAY`+2·`DMA_LEN` cycles (321 with defaults).
- CPU pass-through is combinational: zero added latency for address/write. Read data arrives 1 cycle after the address, as in the MMU.
- CPU access in the same cycle busy falls is blocked. The first granted cycle is the one after.

## Configuration
- `OAM_DMA_ECHO_CLAMP_EN`
  - Defined: source pages 0xE0–0xFF are mapped to page−0x20 (echo RAM behaviour of real hardware).
  - Undefined: the source page is used verbatim.

## Structure
- Shared package `gb_mem_pkg` holds:
  - Constants `ADDR_DMA_REG=16'hFF46`, `ADDR_OAM_BASE=16'hFE00`, `DMA_LEN_DEFAULT=160`.
  - The 2-bit state encoding.
- One natural sub-module, `oam_dma_seq`: state machine, counter, source/destination address generation.
- The top level keeps the port mux, the 0xFF46 decode and the read-data select.

## Test plan
- Pass-through: in IDLE, CPU writes 8'hA5 to 16'h8010, then reads it. Required: `oMemWe` pulse at 8010; `oCpuData=8'hA5` one cycle later.
- Full DMA: preload C000–C09F with i^8'h3C, write 8'hC0 to FF46. Required:
  - `oDmaBusy` high for 321 cycles.
  - FE00+i == i^8'h3C.
  - Exactly 160 `oMemWe` pulses.
- Blocking: during DMA, CPU reads 16'h8000 and writes 16'h8000. Required: read returns 8'hFF; no write reaches the port; 8000 unchanged afterwards.
- Re-trigger: at byte 50, write 8'hD0 to FF46. Required: busy continuous; transfer restarts from D000 to FE00; total busy = 101+321 cycles.
- Reset mid-transfer: drop `iReset` at byte 80. Required: immediately `oDmaBusy=0`, `oMemWe=0`, `oCpuData=8'hFF`; FE00–FE4F hold copied data.
- Echo clamp: write 8'hE1 to FF46. Required: source E100 without `OAM_DMA_ECHO_CLAMP_EN`, C100 with it; FF46 reads back 8'hE1 in both.
